// File: rtl/fir_tap_line.sv
// Multi-channel tap delay line: per-channel NUM_TAPS-deep sample history with fill tracking,
// presenting the updated tap vector of the written channel on a registered valid/ready output.
module fir_tap_line #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_TAPS     = 8,
   parameter int NUM_CHANNELS = 4,
   localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [CH_W-1:0]                in_chan,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH*NUM_TAPS-1:0] out_taps,
   output logic [CH_W-1:0]                out_chan,
   output logic                           out_primed,
   output logic                           err_chan
);

   localparam int VW = DATA_WIDTH * NUM_TAPS;
   localparam int FW = $clog2(NUM_TAPS + 1);
   localparam logic [FW-1:0]   FILL_FULL = FW'(NUM_TAPS);
   localparam logic [CH_W:0]   NUM_CH_L  = (CH_W + 1)'(NUM_CHANNELS);

   logic                    accept;
   logic                    chan_ok;
   logic [NUM_CHANNELS-1:0] chan_hit;
   logic [VW-1:0]           hist_w [NUM_CHANNELS];
   logic [FW-1:0]           fill_w [NUM_CHANNELS];

   logic [VW-1:0]   sel_vec_d;
   logic            sel_primed_d;
   logic [CH_W-1:0] out_chan_d;

   logic            out_valid_q;
   logic [VW-1:0]   out_taps_q;
   logic [CH_W-1:0] out_chan_q;
   logic            out_primed_q;
   logic            err_chan_q;

   assign in_ready = !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign chan_ok  = (NUM_CHANNELS == 1) || ({1'b0, in_chan} < NUM_CH_L);

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
         localparam logic [CH_W-1:0] GI_L = CH_W'(gi);
         logic [VW-1:0] hist_q, hist_d;
         logic [FW-1:0] fill_q, fill_d;

         assign chan_hit[gi] = accept && chan_ok && ((NUM_CHANNELS == 1) || (in_chan == GI_L));
         // Tap 0 sits in the low slice, so shifting toward older taps is a left shift.
         assign hist_d = {hist_q[VW-DATA_WIDTH-1:0], in_data};
         assign fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               hist_q <= '0;
               fill_q <= '0;
            end else if (chan_hit[gi]) begin
               hist_q <= hist_d;
               fill_q <= fill_d;
            end
         end

         assign hist_w[gi] = hist_d;
         assign fill_w[gi] = fill_d;
      end
   endgenerate

   always_comb begin
      sel_vec_d    = '0;
      sel_primed_d = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (chan_hit[i]) begin
            sel_vec_d    = hist_w[i];
            sel_primed_d = (fill_w[i] == FILL_FULL);
         end
      end
   end

   assign out_chan_d = (NUM_CHANNELS == 1) ? '0 : in_chan;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid_q  <= 1'b0;
         out_taps_q   <= '0;
         out_chan_q   <= '0;
         out_primed_q <= 1'b0;
         err_chan_q   <= 1'b0;
      end else begin
         err_chan_q <= accept && !chan_ok;
         if (accept && chan_ok) begin
            out_valid_q  <= 1'b1;
            out_taps_q   <= sel_vec_d;
            out_chan_q   <= out_chan_d;
            out_primed_q <= sel_primed_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_taps   = out_taps_q;
   assign out_chan   = out_chan_q;
   assign out_primed = out_primed_q;
   assign err_chan   = err_chan_q;

endmodule

// File: tb/tb_fir_tap_line.sv
// Directed bench for fir_tap_line: table of per-cycle vectors plus hand sequences for
// backpressure, flush, reset and out-of-range channel behaviour.
module tb_fir_tap_line;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_ready, flush, out_valid, out_ready, out_primed, err_chan;
   logic [15:0]  in_data;
   logic [1:0]   in_chan, out_chan;
   logic [127:0] out_taps;

   logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_primed, b_err_chan;
   logic [15:0]  b_in_data;
   logic [1:0]   b_in_chan, b_out_chan;
   logic [127:0] b_out_taps;

   fir_tap_line u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_chan(in_chan), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_taps(out_taps), .out_chan(out_chan), .out_primed(out_primed), .err_chan(err_chan)
   );

   fir_tap_line #(.NUM_CHANNELS(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_chan(b_in_chan), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_taps(b_out_taps), .out_chan(b_out_chan), .out_primed(b_out_primed), .err_chan(b_err_chan)
   );

   typedef struct {
      logic         v;
      logic         fl;
      logic [1:0]   ch;
      logic [15:0]  d;
      logic         rdy;
      logic         exp_in_rdy;
      logic         exp_v;
      logic         chk_data;
      logic [1:0]   exp_ch;
      logic [127:0] exp_taps;
      logic         exp_pr;
   } vec_t;

   vec_t vecs [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic v, input logic fl, input logic [1:0] ch, input logic [15:0] d,
                                input logic rdy, input logic erdy, input logic ev, input logic cd,
                                input logic [1:0] ech, input logic [127:0] et, input logic ep);
      vec_t r;
      r.v = v; r.fl = fl; r.ch = ch; r.d = d; r.rdy = rdy; r.exp_in_rdy = erdy; r.exp_v = ev;
      r.chk_data = cd; r.exp_ch = ech; r.exp_taps = et; r.exp_pr = ep;
      return r;
   endfunction

   function automatic logic [127:0] tv2(input logic [15:0] t0, input logic [15:0] t1);
      return {96'h0, t1, t0};
   endfunction

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         in_valid = vecs[i].v; flush = vecs[i].fl; in_chan = vecs[i].ch;
         in_data = vecs[i].d; out_ready = vecs[i].rdy;
         #1 chk("vec_in_ready", i, 128'(in_ready), 128'(vecs[i].exp_in_rdy));
         @(posedge clk); #1;
         chk("vec_out_valid", i, 128'(out_valid), 128'(vecs[i].exp_v));
         if (vecs[i].chk_data) begin
            chk("vec_out_taps", i, out_taps, vecs[i].exp_taps);
            chk("vec_out_chan", i, 128'(out_chan), 128'(vecs[i].exp_ch));
            chk("vec_out_primed", i, 128'(out_primed), 128'(vecs[i].exp_pr));
         end
         $display("vec %0d: v=%0b fl=%0b ch=%0d d=%h -> out_valid=%0b tap0=%h", i, vecs[i].v,
                  vecs[i].fl, vecs[i].ch, vecs[i].d, out_valid, out_taps[15:0]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] e;
      int sent, rcvd;
      logic acc;

      // Priming: ch0 samples 1..9 (entries 0..8)
      for (int s = 1; s <= 9; s++) begin
         e = '0;
         for (int k = 0; k < 8; k++) if (s - k >= 1) e[k*16 +: 16] = 16'(s - k);
         vecs.push_back(mkv(1, 0, 2'd0, 16'(s), 1, 1, 1, 1, 2'd0, e, s >= 8));
      end
      // Flush with a sample offered (entry 9), then channel isolation (10..17)
      vecs.push_back(mkv(1, 1, 2'd0, 16'hAAAA, 1, 0, 0, 1, 2'd0, 128'h0, 0));
      vecs.push_back(mkv(1, 0, 2'd0, 16'h10, 1, 1, 1, 1, 2'd0, tv2(16'h10, 16'h0), 0));
      vecs.push_back(mkv(1, 0, 2'd1, 16'h20, 1, 1, 1, 1, 2'd1, tv2(16'h20, 16'h0), 0));
      vecs.push_back(mkv(1, 0, 2'd0, 16'h11, 1, 1, 1, 1, 2'd0, tv2(16'h11, 16'h10), 0));
      vecs.push_back(mkv(1, 0, 2'd3, 16'h30, 1, 1, 1, 1, 2'd3, tv2(16'h30, 16'h0), 0));
      vecs.push_back(mkv(1, 0, 2'd2, 16'h40, 1, 1, 1, 1, 2'd2, tv2(16'h40, 16'h0), 0));
      vecs.push_back(mkv(1, 0, 2'd1, 16'h21, 1, 1, 1, 1, 2'd1, tv2(16'h21, 16'h20), 0));
      vecs.push_back(mkv(1, 0, 2'd0, 16'h12, 0, 0, 1, 1, 2'd1, tv2(16'h21, 16'h20), 0));
      vecs.push_back(mkv(1, 0, 2'd0, 16'h12, 1, 1, 1, 1, 2'd0, {80'h0, 16'h10, 16'h11, 16'h12}, 0));
      vecs.push_back(mkv(0, 0, 2'd0, 16'h0, 1, 1, 0, 0, 2'd0, 128'h0, 0));

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_chan = '0; b_out_ready = 1'b0; b_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 0, 128'(out_valid), 128'h0);
      chk("rst_out_taps", 0, out_taps, 128'h0);
      chk("rst_out_chan", 0, 128'(out_chan), 128'h0);
      chk("rst_out_primed", 0, 128'(out_primed), 128'h0);
      chk("rst_err_chan", 0, 128'(err_chan), 128'h0);
      chk("rst_b_out_valid", 0, 128'(b_out_valid), 128'h0);
      @(negedge clk) rst = 1'b0;

      run_vecs(0, 8);
      run_vecs(9, vecs.size() - 1);

      // Backpressure: one accept, then a 5-cycle stall with a new sample offered
      @(negedge clk); flush = 1'b1; in_valid = 1'b0;
      @(negedge clk); flush = 1'b0;
      in_valid = 1'b1; in_chan = 2'd0; in_data = 16'h100; out_ready = 1'b0;
      #1 chk("bp_first_in_ready", 0, 128'(in_ready), 128'h1);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); in_data = 16'h101; out_ready = 1'b0;
         #1 chk("bp_stall_in_ready", c, 128'(in_ready), 128'h0);
         @(posedge clk); #1;
         chk("bp_stall_valid", c, 128'(out_valid), 128'h1);
         chk("bp_stall_taps", c, out_taps, tv2(16'h100, 16'h0));
         chk("bp_stall_chan", c, 128'(out_chan), 128'h0);
         $display("stall %0d: out_valid=%0b tap0=%h in_ready=%0b", c, out_valid, out_taps[15:0], in_ready);
      end

      // Burst of 20 more samples with intermittent out_ready; scoreboard on transfer order
      sent = 1; rcvd = 0;
      for (int cyc = 0; cyc < 300 && rcvd < 21; cyc++) begin
         @(negedge clk);
         if (cyc == 1) chk("release_valid_held", cyc, 128'(out_valid), 128'h1);
         in_valid = (sent < 21);
         in_data = 16'h100 + 16'(sent);
         out_ready = (cyc % 4 != 3);
         #1;
         if (out_valid && out_ready) begin
            chk("burst_tap0", rcvd, 128'(out_taps[15:0]), 128'(16'h100 + 16'(rcvd)));
            chk("burst_tap1", rcvd, 128'(out_taps[31:16]), (rcvd == 0) ? 128'h0 : 128'(16'h100 + 16'(rcvd - 1)));
            chk("burst_primed", rcvd, 128'(out_primed), 128'(rcvd + 1 >= 8));
            $display("burst xfer %0d: tap0=%h tap1=%h primed=%0b", rcvd, out_taps[15:0], out_taps[31:16], out_primed);
            rcvd++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) sent++;
      end
      chk("burst_count", 0, 128'(rcvd), 128'd21);
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;

      // Flush mid-stream: prime ch1, then flush with in_valid=1 and out_valid=1
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); in_valid = 1'b1; in_chan = 2'd1; in_data = 16'h200 + 16'(i); out_ready = 1'b1;
         @(posedge clk); #1;
      end
      chk("fl_primed_before", 0, 128'(out_primed), 128'h1);
      chk("fl_tap0_before", 0, 128'(out_taps[15:0]), 128'h207);
      chk("fl_tap7_before", 0, 128'(out_taps[127:112]), 128'h200);
      @(negedge clk); flush = 1'b1; in_data = 16'h999; out_ready = 1'b0;
      #1 chk("fl_in_ready", 0, 128'(in_ready), 128'h0);
      @(posedge clk); #1;
      chk("fl_out_valid", 0, 128'(out_valid), 128'h0);
      chk("fl_out_taps", 0, out_taps, 128'h0);
      chk("fl_out_primed", 0, 128'(out_primed), 128'h0);
      @(negedge clk); flush = 1'b0; in_valid = 1'b1; in_chan = 2'd1; in_data = 16'h55; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("fl_after_valid", 0, 128'(out_valid), 128'h1);
      chk("fl_after_taps", 0, out_taps, tv2(16'h55, 16'h0));
      chk("fl_after_chan", 0, 128'(out_chan), 128'h1);
      chk("fl_after_primed", 0, 128'(out_primed), 128'h0);
      $display("flush: post-flush ch1 tap0=%h primed=%0b", out_taps[15:0], out_primed);

      // Reset with pending output, stalled consumer and flush all at once
      @(negedge clk); in_valid = 1'b1; in_chan = 2'd2; in_data = 16'h77; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("rm_pending_valid", 0, 128'(out_valid), 128'h1);
      @(negedge clk); rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      chk("rm_out_valid", 0, 128'(out_valid), 128'h0);
      chk("rm_out_taps", 0, out_taps, 128'h0);
      chk("rm_out_chan", 0, 128'(out_chan), 128'h0);
      chk("rm_out_primed", 0, 128'(out_primed), 128'h0);
      chk("rm_err_chan", 0, 128'(err_chan), 128'h0);
      $display("reset mid-op: out_valid=%0b taps=%h", out_valid, out_taps);
      @(negedge clk); rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      run_vecs(0, 8);

      // Out-of-range channel on the 3-channel instance
      @(negedge clk); b_in_valid = 1'b1; b_in_chan = 2'd0; b_in_data = 16'h1; b_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bad_pre_valid", 0, 128'(b_out_valid), 128'h1);
      chk("bad_pre_err", 0, 128'(b_err_chan), 128'h0);
      @(negedge clk); b_in_chan = 2'd3; b_in_data = 16'hBEEF;
      #1 chk("bad_in_ready", 0, 128'(b_in_ready), 128'h1);
      @(posedge clk); #1;
      chk("bad_err_pulse", 0, 128'(b_err_chan), 128'h1);
      chk("bad_valid_dropped", 0, 128'(b_out_valid), 128'h0);
      $display("bad chan: err_chan=%0b out_valid=%0b", b_err_chan, b_out_valid);
      @(negedge clk); b_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bad_err_oneshot", 0, 128'(b_err_chan), 128'h0);
      @(negedge clk); b_in_valid = 1'b1; b_in_chan = 2'd3; b_in_data = 16'hBEEF;
      @(posedge clk); #1;
      chk("bad_err_idle", 0, 128'(b_err_chan), 128'h1);
      chk("bad_valid_idle", 0, 128'(b_out_valid), 128'h0);
      @(negedge clk); b_in_chan = 2'd0; b_in_data = 16'h2;
      @(posedge clk); #1;
      chk("bad_next_err", 0, 128'(b_err_chan), 128'h0);
      chk("bad_next_valid", 0, 128'(b_out_valid), 128'h1);
      chk("bad_next_taps", 0, b_out_taps, tv2(16'h2, 16'h1));
      chk("bad_next_primed", 0, 128'(b_out_primed), 128'h0);
      $display("bad chan: next ch0 taps=%h", b_out_taps);
      @(negedge clk); b_in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_tap_line.md
Name: fir_tap_line

Overview:
Parametrised multi-channel tap delay line for the FIR datapath. It keeps an independent NUM_TAPS-deep shift history per channel and takes one sample per accepted transfer on a valid/ready input. After each accepted sample it presents that channel's full tap vector on a registered valid/ready output. It sits between the sample source and the MAC array, and adds per-channel fill tracking, backpressure and flush.

Parameters:
DATA_WIDTH, 16, sample width in bits
NUM_TAPS, 8, taps per channel (>=2)
NUM_CHANNELS, 4, independent channel histories (>=1)
CH_W, max(1,$clog2(NUM_CHANNELS)), channel index width (derived, localparam)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept this cycle
in_data  in  DATA_WIDTH  sample
in_chan  in  CH_W  target channel of sample
flush  in  1  synchronous clear of all histories and output
out_valid  out  1  tap vector available
out_ready  in  1  consumer accepts tap vector
out_taps  out  DATA_WIDTH*NUM_TAPS  tap k at [k*DATA_WIDTH +: DATA_WIDTH]; k=0 newest
out_chan  out  CH_W  channel of out_taps
out_primed  out  1  channel had received >= NUM_TAPS samples, including this one, since the last reset or flush
err_chan  out  1  one-cycle pulse: accepted sample had in_chan >= NUM_CHANNELS

Behaviour:
- Reset (rst=1 at posedge): every tap of every channel = 0, fill counters = 0, out_valid=0, out_taps=0, out_chan=0, out_primed=0, err_chan=0. rst overrides flush and all handshakes.
- in_ready = !flush && (!out_valid || out_ready). Purely combinational. There is no path from in_valid or in_data to in_ready.
- Accept = in_valid && in_ready.
- Accept with c = in_chan < NUM_CHANNELS, at the same posedge:
  - tap[c][k] <= tap[c][k-1] for k = NUM_TAPS-1..1; tap[c][0] <= in_data.
  - fill[c] <= min(fill[c]+1, NUM_TAPS), saturating with no wrap.
  - Output register loads the post-shift vector of c, out_chan=c, out_primed=(new fill[c]==NUM_TAPS), out_valid=1.
  - Latency: sample accepted at edge N appears on out_taps[0] after edge N (valid in cycle N+1).
- Other channels are untouched by an accept.
- Accept with in_chan >= NUM_CHANNELS: no history or fill changes. err_chan=1 for exactly the following cycle. The output register is not loaded. If out_valid was 1 and out_ready=1, out_valid drops to 0.
- Output handshake: out_valid, out_taps, out_chan and out_primed stay stable while out_valid && !out_ready.
  - Transfer when out_valid && out_ready.
  - With no new accept in that cycle, out_valid <= 0.
  - Simultaneous transfer and new accept: the output reloads with the new vector and out_valid stays 1, giving full throughput of one sample per cycle.
- flush=1 (rst=0): all taps and fills <= 0, out_valid <= 0, out_taps, out_chan and out_primed <= 0, err_chan <= 0.
  - in_ready is 0 that cycle, so no sample is lost silently; the source retains it.
  - A pending output is discarded.
- No arithmetic on samples; data is passed bit-exact. The fill counter is sized $clog2(NUM_TAPS+1) bits per channel.
- NUM_CHANNELS=1: in_chan is ignored for indexing, and err_chan never asserts.

Test Plan:
- Reset/priming (defaults): rst 2 cycles, then feed ch0 samples 1..8 with out_ready=1 -> after sample 8 out_taps = {8,7,6,5,4,3,2,1} (tap0=8, tap7=1); out_primed=0 for samples 1..7 and 1 at 8; then sample 9 -> tap0=9, tap7=2, out_primed=1.
- Channel isolation: interleave ch0=0x10,ch1=0x20,ch0=0x11,ch3=0x30 -> ch0 output tap0=0x11, tap1=0x10; ch1 tap0=0x20, rest 0; ch3 tap0=0x30; ch2 fill stays 0.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, out_* stable for 5 cycles. Release out_ready with in_valid held -> transfer and new accept in the same cycle, out_valid stays 1, no sample dropped or duplicated (check with 20-sample back-to-back burst, scoreboard order).
- Bad channel: NUM_CHANNELS=3, in_chan=3 with data 0xBEEF -> err_chan pulses one cycle, no history changes, out_valid not raised; next valid ch0 sample shows no 0xBEEF in any tap.
- Flush mid-stream: prime ch1 with 8 samples, assert flush while in_valid=1 and out_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle; next ch1 sample 0x55 gives tap0=0x55, taps1..7=0, out_primed=0.
- Reset mid-operation: rst with out_valid=1, out_ready=0 and flush=1 simultaneously -> all outputs 0 after the edge; repeat the priming test and match the first result.
